// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of four writeback sources through an IDLE/SELECT/WRITE FSM.
// Define WB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority ALU > load > PC link > immediate.
module wb_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Req,
  input  logic [4:0] Rd0,
  input  logic [4:0] Rd1,
  input  logic [4:0] Rd2,
  input  logic [4:0] Rd3,
  output logic [1:0] SEL,
  output logic [3:0] Ack,
  output logic       RegWrite,
  output logic [4:0] Rd_Out,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, SELECT, WRITE} state_t;

  state_t     state_reg;
  logic [1:0] win;
  logic [4:0] rd_win;

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] ptr_reg;
  logic [1:0] idx;
  logic       found;

  // Search starts at the pointer and wraps from 3 back to 0.
  always_comb begin
    win   = ptr_reg;
    idx   = ptr_reg;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_reg + 2'(i);
      if (!found && Req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    if (Req[0])      win = 2'd0;
    else if (Req[1]) win = 2'd1;
    else if (Req[2]) win = 2'd2;
    else             win = 2'd3;
  end
`endif

  always_comb begin
    case (win)
      2'd0:    rd_win = Rd0;
      2'd1:    rd_win = Rd1;
      2'd2:    rd_win = Rd2;
      default: rd_win = Rd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      SEL       <= 2'd0;
      Rd_Out    <= 5'd0;
      Ack       <= 4'd0;
      RegWrite  <= 1'b0;
      Busy      <= 1'b0;
`ifdef WB_ROUND_ROBIN_EN
      ptr_reg   <= 2'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|Req) begin
            SEL       <= win;
            Rd_Out    <= rd_win;
            Busy      <= 1'b1;
            state_reg <= SELECT;
          end
        end
        SELECT: begin
          // Writes to register 0 are acknowledged but never performed.
          Ack       <= 4'b0001 << SEL;
          RegWrite  <= (Rd_Out != 5'd0);
          state_reg <= WRITE;
        end
        WRITE: begin
          Ack       <= 4'd0;
          RegWrite  <= 1'b0;
          Busy      <= 1'b0;
          state_reg <= IDLE;
`ifdef WB_ROUND_ROBIN_EN
          ptr_reg   <= SEL + 2'd1;
`endif
        end
        default: begin
          Ack       <= 4'd0;
          RegWrite  <= 1'b0;
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
